// File: rtl/treasure_detect_ctrl_pkg.sv
// Shared encodings and defaults for the colour-treasure detection sequencer.
package treasure_detect_ctrl_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_RED  = 2'b01,
    RES_BLUE = 2'b10
  } res_t;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    DECIDE
  } state_t;

  localparam int unsigned DEF_SCREEN_WIDTH  = 176;
  localparam int unsigned DEF_SCREEN_HEIGHT = 144;

endpackage

// File: rtl/treasure_detect_ctrl_if.sv
// Pixel stream in, debounced class out, with valid/ack toward the Arduino link.
interface treasure_detect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [7:0]       PIXEL_IN;
  logic             PIXEL_VALID;
  logic [9:0]       VGA_PIXEL_X;
  logic [9:0]       VGA_PIXEL_Y;
  logic             VGA_VSYNC_NEG;
  logic [CNT_W-1:0] THRESH;
  logic [1:0]       RESULT;
  logic             RESULT_VALID;
  logic             RESULT_ACK;
  logic [CNT_W-1:0] LAST_RED_CNT;
  logic [CNT_W-1:0] LAST_BLUE_CNT;

  modport master (
    output PIXEL_IN, PIXEL_VALID, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
           THRESH, RESULT_ACK,
    input  RESULT, RESULT_VALID, LAST_RED_CNT, LAST_BLUE_CNT
  );

  modport slave (
    input  PIXEL_IN, PIXEL_VALID, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
           THRESH, RESULT_ACK,
    output RESULT, RESULT_VALID, LAST_RED_CNT, LAST_BLUE_CNT
  );
endinterface

// File: rtl/treasure_detect_ctrl_pixel_classifier.sv
// Combinational RGB332 pixel classifier: dominant red or dominant blue, ties are neither.
module pixel_classifier (
  input  logic [7:0] pixel_in,
  output logic       is_red,
  output logic       is_blue
);
  logic [1:0] r, g, b;
  // R[5] and G[2] sit below the 2-bit comparison precision
  logic unused_bits;

  always_comb begin
    r           = pixel_in[7:6];
    g           = pixel_in[4:3];
    b           = pixel_in[1:0];
    unused_bits = ^{pixel_in[5], pixel_in[2]};
    is_red      = (r > g) && (r > b);
    is_blue     = (b > r) && (b > g);
  end
endmodule

// File: rtl/treasure_detect_ctrl.sv
// Frame sequencer: counts red/blue pixels per VSYNC-delimited frame, debounces
// the per-frame class and publishes it with a valid/ack handshake.
module treasure_detect_ctrl
  import treasure_detect_ctrl_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input logic                  CLK,
  input logic                  RESET_N,
  treasure_detect_ctrl_if.slave bus
);
  localparam int unsigned      STAB_W   = $clog2(STABLE_FRAMES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_FRAMES);
  localparam logic [9:0]       X_LIM    = 10'(SCREEN_WIDTH);
  localparam logic [9:0]       Y_LIM    = 10'(SCREEN_HEIGHT);

  state_t            state;
  logic              vs_q, fall;
  logic [CNT_W-1:0]  red_cnt, blue_cnt, last_red, last_blue;
  res_t              cand, frame_cls, result;
  logic [STAB_W-1:0] stab, stab_nx;
  logic              result_valid, publish, is_red, is_blue, in_window;

  pixel_classifier u_classifier (
    .pixel_in (bus.PIXEL_IN),
    .is_red   (is_red),
    .is_blue  (is_blue)
  );

  always_comb begin
    in_window = bus.PIXEL_VALID && (bus.VGA_PIXEL_X < X_LIM) && (bus.VGA_PIXEL_Y < Y_LIM);
    frame_cls = RES_NONE;
    if (red_cnt > blue_cnt && red_cnt >= bus.THRESH)
      frame_cls = RES_RED;
    else if (blue_cnt > red_cnt && blue_cnt >= bus.THRESH)
      frame_cls = RES_BLUE;
    if (frame_cls == cand)
      stab_nx = (stab == STAB_MAX) ? stab : stab + STAB_W'(1);
    else
      stab_nx = STAB_W'(1);
    // Uses the post-update debounce state so the publish lands with this DECIDE.
    publish = (stab_nx == STAB_MAX) && (frame_cls != result) && !result_valid;
  end

  always_comb begin
    bus.RESULT        = result;
    bus.RESULT_VALID  = result_valid;
    bus.LAST_RED_CNT  = last_red;
    bus.LAST_BLUE_CNT = last_blue;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= WAIT_FRAME;
      vs_q         <= 1'b0;
      fall         <= 1'b0;
      red_cnt      <= '0;
      blue_cnt     <= '0;
      last_red     <= '0;
      last_blue    <= '0;
      cand         <= RES_NONE;
      stab         <= '0;
      result       <= RES_NONE;
      result_valid <= 1'b0;
    end else begin
      vs_q <= bus.VGA_VSYNC_NEG;
      fall <= vs_q && !bus.VGA_VSYNC_NEG;

      if (result_valid && bus.RESULT_ACK)
        result_valid <= 1'b0;

      case (state)
        WAIT_FRAME: begin
          if (fall) begin
            red_cnt  <= '0;
            blue_cnt <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (fall) begin
            state <= DECIDE;
          end else if (in_window) begin
            if (is_red && red_cnt != '1)
              red_cnt <= red_cnt + CNT_W'(1);
            if (is_blue && blue_cnt != '1)
              blue_cnt <= blue_cnt + CNT_W'(1);
          end
        end
        DECIDE: begin
          last_red  <= red_cnt;
          last_blue <= blue_cnt;
          cand      <= frame_cls;
          stab      <= stab_nx;
          if (publish) begin
            result       <= frame_cls;
            result_valid <= 1'b1;
          end
          red_cnt  <= '0;
          blue_cnt <= '0;
          state    <= ACCUM;
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end
endmodule

// File: tb/tb_treasure_detect_ctrl.sv
// Randomized scoreboard bench for treasure_detect_ctrl (16-bit and 8-bit counter instances).
module tb_treasure_detect_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  treasure_detect_ctrl_if #(.CNT_W(16)) bus ();
  treasure_detect_ctrl_if #(.CNT_W(8))  bus8 ();

  assign bus8.PIXEL_IN      = bus.PIXEL_IN;
  assign bus8.PIXEL_VALID   = bus.PIXEL_VALID;
  assign bus8.VGA_PIXEL_X   = bus.VGA_PIXEL_X;
  assign bus8.VGA_PIXEL_Y   = bus.VGA_PIXEL_Y;
  assign bus8.VGA_VSYNC_NEG = bus.VGA_VSYNC_NEG;
  assign bus8.THRESH        = bus.THRESH[7:0];
  assign bus8.RESULT_ACK    = bus.RESULT_ACK;

  treasure_detect_ctrl #(
    .SCREEN_WIDTH(176), .SCREEN_HEIGHT(144), .CNT_W(16), .STABLE_FRAMES(3)
  ) dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));

  treasure_detect_ctrl #(
    .SCREEN_WIDTH(176), .SCREEN_HEIGHT(144), .CNT_W(8), .STABLE_FRAMES(3)
  ) dut8 (.CLK(clk), .RESET_N(rst_n), .bus(bus8));

  typedef struct { int unsigned at; logic [1:0] res; } pub_t;
  typedef struct { int unsigned at; int r16; int b16; int r8; int b8; } cnt_t;

  pub_t pub_q[$];
  cnt_t cnt_q[$];

  int checks = 0;
  int passed = 0;
  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model state
  int   red_acc = 0, blue_acc = 0, thresh = 0;
  int   hist[$];
  int   m_result = 0;
  bit   m_valid = 0, m_started = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic int pix_class(input logic [7:0] p);
    int r, g, b;
    r = int'(p[7:6]); g = int'(p[4:3]); b = int'(p[1:0]);
    if (r > g && r > b) return 1;
    if (b > r && b > g) return 2;
    return 0;
  endfunction

  function automatic bit rnd_ack();
    return $urandom_range(0, 5) == 0;
  endfunction

  function automatic logic [7:0] gen_pix(input int theme);
    logic [7:0] p;
    p = 8'($urandom);
    if ((theme == 1 || theme == 2) && $urandom_range(0, 3) == 0) return p;
    case (theme)
      1: begin p[7:6] = 2'b11; p[4:3] = 2'($urandom_range(0, 2)); p[1:0] = 2'($urandom_range(0, 2)); end
      2: begin p[1:0] = 2'b11; p[4:3] = 2'($urandom_range(0, 2)); p[7:6] = 2'($urandom_range(0, 2)); end
      3, 5: p = 8'hE0;
      4: p = 8'h03;
      default: ;
    endcase
    return p;
  endfunction

  task automatic decide(input int unsigned at, input bit pre);
    int r16, b16, cls, run;
    r16 = sat(red_acc, 65535);
    b16 = sat(blue_acc, 65535);
    cnt_q.push_back('{at, r16, b16, sat(red_acc, 255), sat(blue_acc, 255)});
    cls = 0;
    if (r16 > b16 && r16 >= thresh) cls = 1;
    else if (b16 > r16 && b16 >= thresh) cls = 2;
    hist.push_back(cls);
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == cls; i--) run++;
    if (!pre && run >= 3 && cls != m_result) begin
      m_result = cls;
      m_valid  = 1;
      pub_q.push_back('{at, 2'(cls)});
    end
    red_acc  = 0;
    blue_acc = 0;
  endtask

  task automatic tick(input logic [7:0] p, input bit pv, input int x, input int y,
                      input bit vs, input bit ack, input bit dec);
    int unsigned e;
    bit pre;
    int c;
    @(negedge clk); #1;
    bus.PIXEL_IN      = p;
    bus.PIXEL_VALID   = pv;
    bus.VGA_PIXEL_X   = 10'(x);
    bus.VGA_PIXEL_Y   = 10'(y);
    bus.VGA_VSYNC_NEG = vs;
    bus.RESULT_ACK    = ack;
    bus.THRESH        = 16'(thresh);
    e = edge_n;
    @(posedge clk);
    pre = m_valid;
    if (pre && ack) m_valid = 0;
    if (dec) decide(e + 1, pre);
    if (m_started && pv && x < 176 && y < 144) begin
      c = pix_class(p);
      if (c == 1) red_acc++;
      else if (c == 2) blue_acc++;
    end
  endtask

  task automatic mid_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_result", bus.RESULT, 0);
    check("rst_valid", bus.RESULT_VALID, 0);
    check("rst_last_red", bus.LAST_RED_CNT, 0);
    check("rst_last_blue", bus.LAST_BLUE_CNT, 0);
    check("rst_last_red8", bus8.LAST_RED_CNT, 0);
    m_started = 0; m_valid = 0; m_result = 0;
    red_acc = 0; blue_acc = 0;
    hist.delete(); pub_q.delete(); cnt_q.delete();
    bus.VGA_VSYNC_NEG = 1'b1;
    bus.PIXEL_VALID   = 1'b0;
    bus.RESULT_ACK    = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One VSYNC fall (closing the previous frame if any), pixels, then blanking.
  task automatic frame(input int theme, input int npix, input bit hold,
                       input bit ack_dec, input int rst_at);
    bit a;
    int x, y;
    for (int i = 0; i < 5; i++) begin
      a = hold ? 1'b0 : rnd_ack();
      if (i == 2 && ack_dec) a = 1'b1;
      tick(8'h00, 1'b0, 0, 0, 1'b0, a, (i == 2) && m_started);
    end
    if (!m_started) begin m_started = 1; red_acc = 0; blue_acc = 0; end
    if (theme == 3) begin
      for (int yy = 0; yy < 144; yy++)
        for (int xx = 0; xx < 176; xx++)
          tick(8'hE0, 1'b1, xx, yy, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < npix; i++) begin
        if (i == rst_at) begin mid_reset(); return; end
        x = $urandom_range(0, 199);
        y = $urandom_range(0, 159);
        if (theme == 4) begin x = $urandom_range(0, 175); y = $urandom_range(0, 143); end
        if (theme == 5) begin
          case (i % 3)
            0: begin x = 176 + $urandom_range(0, 24); y = $urandom_range(0, 143); end
            1: begin x = $urandom_range(0, 175); y = 150; end
            default: begin x = $urandom_range(0, 175); y = $urandom_range(0, 143); end
          endcase
        end
        a = hold ? 1'b0 : rnd_ack();
        tick(gen_pix(theme), (theme >= 3) ? 1'b1 : ($urandom_range(0, 7) != 0), x, y, 1'b0, a, 1'b0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      a = hold ? 1'b0 : rnd_ack();
      tick(8'h00, 1'b0, 0, 0, 1'b1, a, 1'b0);
    end
  endtask

  // Monitor: pops the scoreboard when the DUT presents a result or new frame counts.
  initial begin
    logic prev_valid;
    logic [1:0] prev_res;
    pub_t e;
    cnt_t c;
    prev_valid = 1'b0;
    prev_res = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_valid) begin
          check("valid_vs_ack", bus.RESULT_VALID, !bus.RESULT_ACK);
          check("result_hold", bus.RESULT, prev_res);
        end else if (bus.RESULT_VALID) begin
          if (pub_q.size() == 0) check("pub_expected", pub_q.size(), 1);
          else begin
            e = pub_q.pop_front();
            check("result", bus.RESULT, e.res);
            check("pub_cycle", edge_n, e.at);
          end
        end
        if (cnt_q.size() != 0 && cnt_q[0].at == edge_n) begin
          c = cnt_q.pop_front();
          check("last_red", bus.LAST_RED_CNT, c.r16);
          check("last_blue", bus.LAST_BLUE_CNT, c.b16);
          check("last_red8", bus8.LAST_RED_CNT, c.r8);
          check("last_blue8", bus8.LAST_BLUE_CNT, c.b8);
        end
      end
      prev_valid = bus.RESULT_VALID;
      prev_res   = bus.RESULT;
    end
  end

  initial begin
    int th, rep;
    bus.PIXEL_IN = 8'h00; bus.PIXEL_VALID = 1'b0;
    bus.VGA_PIXEL_X = '0; bus.VGA_PIXEL_Y = '0;
    bus.VGA_VSYNC_NEG = 1'b1; bus.THRESH = '0; bus.RESULT_ACK = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.RESULT, 0);
    check("reset_valid", bus.RESULT_VALID, 0);
    check("reset_last_red", bus.LAST_RED_CNT, 0);
    check("reset_last_blue", bus.LAST_BLUE_CNT, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tick(8'hE0, 1'b1, 5, 5, 1'b1, 1'b0, 1'b0);

    thresh = 30000;
    repeat (4) frame(4, 150, 0, 0, -1);
    thresh = 100;
    frame(3, 0, 0, 0, -1);
    repeat (2) frame(1, 300, 0, 0, -1);
    repeat (4) frame(2, 300, 1, 0, -1);
    frame(2, 300, 1, 1, -1);
    frame(2, 300, 1, 0, -1);
    thresh = 10;
    frame(5, 120, 0, 0, -1);

    for (int f = 0; f < 30; ) begin
      th = $urandom_range(0, 2);
      rep = $urandom_range(1, 4);
      thresh = $urandom_range(0, 200);
      for (int k = 0; k < rep; k++, f++) frame(th, $urandom_range(100, 300), 0, 0, -1);
    end

    frame(1, 200, 0, 0, 100);
    thresh = 50;
    for (int f = 0; f < 5; f++) frame(1, 250, 0, 0, -1);
    frame(0, 0, 0, 0, -1);
    repeat (5) tick(8'h00, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);

    check("pub_queue_drained", pub_q.size(), 0);
    check("cnt_queue_drained", cnt_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
